// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an input word FIFO and internal baud divider.
// Frame: start bit, DATA_W data bits (order from MSB_FIRST), optional parity,
// STOP_BITS stop bits. Each bit is held for CLKS_PER_BIT clk cycles.
// Optional feature macro: UART_TX_PARITY_EN adds the parity_odd port and the
// PARITY state (parity = XOR(data) ^ parity_odd, captured when the word is popped).
//
// state  | meaning
// IDLE   | line high, waiting for the FIFO to hold a word
// START  | start bit (tx low)
// DATA   | shifting data bits out
// PARITY | parity bit (only with UART_TX_PARITY_EN)
// STOP   | stop bit(s), tx high; pops the next word at the end if one is waiting
module uart_tx_fifo #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int MSB_FIRST    = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef UART_TX_PARITY_EN
  ,
  input  logic                          parity_odd
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = 4;
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DATA_LAST  = CW'(DATA_W - 1);
  localparam logic [CW-1:0] STOP_LAST  = CW'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              push, pop, fifo_empty, bit_done;

  state_t            state, state_next;
  logic [BW-1:0]     baud_cnt, baud_next;
  logic [CW-1:0]     bit_cnt, bit_next;
  logic [DATA_W-1:0] shreg, shreg_next;
  logic              tx_next;
`ifdef UART_TX_PARITY_EN
  logic              par_bit, par_next;
`endif

  // Next serial data bit taken from the end of the shift register selected by MSB_FIRST.
  function automatic logic out_bit(input logic [DATA_W-1:0] v);
    return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
  endfunction

  function automatic logic [DATA_W-1:0] shifted(input logic [DATA_W-1:0] v);
    return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
  endfunction

  // in_ready looks only at the registered level, so a full FIFO refuses a push
  // even when a pop happens on the same edge.
  assign in_ready   = (fifo_level != FULL_LEVEL);
  assign push       = in_valid && in_ready;
  assign fifo_empty = (fifo_level == '0);
  assign busy       = (state != IDLE) || !fifo_empty;
  assign bit_done   = (baud_cnt == BAUD_LAST);

  // FIFO storage; no reset needed, contents are qualified by the level.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // FIFO pointers and level; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: ;
      endcase
    end
  end

  // FSM next-state and datapath next values; pop overrides to start a new frame.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_cnt;
    shreg_next = shreg;
    tx_next    = tx;
    pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_next   = par_bit;
`endif
    if (state != IDLE) baud_next = bit_done ? '0 : baud_cnt + 1'b1;
    case (state)
      IDLE: begin
        if (!fifo_empty) pop = 1'b1;
      end
      START: begin
        if (bit_done) begin
          tx_next    = out_bit(shreg);
          shreg_next = shifted(shreg);
          bit_next   = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_cnt == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
            tx_next    = par_bit;
            state_next = PARITY;
`else
            tx_next    = 1'b1;
            bit_next   = '0;
            state_next = STOP;
`endif
          end else begin
            tx_next    = out_bit(shreg);
            shreg_next = shifted(shreg);
            bit_next   = bit_cnt + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          tx_next    = 1'b1;
          bit_next   = '0;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          if (bit_cnt == STOP_LAST) begin
            if (!fifo_empty) pop = 1'b1;
            else             state_next = IDLE;
          end else begin
            bit_next = bit_cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (pop) begin
      shreg_next = mem[rd_ptr];
      tx_next    = 1'b0;
      baud_next  = '0;
      state_next = START;
`ifdef UART_TX_PARITY_EN
      par_next   = (^mem[rd_ptr]) ^ parity_odd;
`endif
    end
  end

  // FSM and serialiser registers; tx comes straight from this flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_cnt  <= bit_next;
      shreg    <= shreg_next;
      tx       <= tx_next;
`ifdef UART_TX_PARITY_EN
      par_bit  <= par_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo. Two instances: defaults, and
// DATA_W=7 / MSB first / 2 stop bits / 4 clk per bit / depth 2. Words are queued
// when accepted; a per-instance line monitor decodes tx and compares frames.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic vld0, vld1, rdy0, rdy1, tx0, tx1, busy0, busy1;
  logic [7:0] d0;
  logic [6:0] d1;
  logic [2:0] lvl0;
  logic [1:0] lvl1;
  logic par_odd;
  logic [1:0] tx_v, busy_v;

  int checks = 0;
  int failures = 0;
  logic [9:0] q0[$], q1[$];
  int gaps0[$], gaps1[$];

  assign tx_v   = {tx1, tx0};
  assign busy_v = {busy1, busy0};

  always #5 clk = ~clk;

  uart_tx_fifo dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld0), .in_ready(rdy0), .in_data(d0),
    .tx(tx0), .busy(busy0), .fifo_level(lvl0)
`ifdef UART_TX_PARITY_EN
    , .parity_odd(par_odd)
`endif
  );

  uart_tx_fifo #(.DATA_W(7), .CLKS_PER_BIT(4), .STOP_BITS(2), .MSB_FIRST(1), .FIFO_DEPTH(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld1), .in_ready(rdy1), .in_data(d1),
    .tx(tx1), .busy(busy1), .fifo_level(lvl1)
`ifdef UART_TX_PARITY_EN
    , .parity_odd(par_odd)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic int lvl_of(input int id);
    return (id == 0) ? int'(lvl0) : int'(lvl1);
  endfunction

  function automatic int qsize(input int id);
    return (id == 0) ? q0.size() : q1.size();
  endfunction

  // Offer a word (called at a negedge); returns at the negedge after the accepting edge.
  task automatic push(input int id, input logic [7:0] w, output int lvl_before);
    int n;
    logic [8:0] we;
    n = 0;
    we = (id == 0) ? {1'b0, w} : {2'b00, w[6:0]};
    if (id == 0) begin vld0 = 1'b1; d0 = w; end
    else         begin vld1 = 1'b1; d1 = w[6:0]; end
    while (!((id == 0) ? rdy0 : rdy1) && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) chk("push_timeout", (id == 0) ? rdy0 : rdy1, 1);
    lvl_before = lvl_of(id);
    if (id == 0) q0.push_back({(^we) ^ par_odd, we});
    else         q1.push_back({(^we) ^ par_odd, we});
    @(negedge clk);
    vld0 = 1'b0;
    vld1 = 1'b0;
  endtask

  task automatic wait_idle(input int id, input string tag);
    int n;
    n = 0;
    while ((qsize(id) != 0 || busy_v[id]) && n < 3000) begin @(negedge clk); n++; end
    chk({tag, "_drain_q"}, qsize(id), 0);
    chk({tag, "_drain_busy"}, busy_v[id], 0);
  endtask

  // One word into an idle instance: latency, no bypass, busy timing and frame length.
  task automatic single_frame(input int id, input logic [7:0] w, input int exp_cycles, input string tag);
    int lb, n;
    push(id, w, lb);
    chk({tag, "_nobypass_tx"}, tx_v[id], 1);
    chk({tag, "_level1"}, lvl_of(id), 1);
    chk({tag, "_busy_hi"}, busy_v[id], 1);
    @(negedge clk);
    chk({tag, "_start_tx"}, tx_v[id], 0);
    chk({tag, "_level0"}, lvl_of(id), 0);
    n = 2;
    while (busy_v[id] && n < 5000) begin @(negedge clk); n++; end
    chk({tag, "_busy_drop_cycle"}, n, exp_cycles);
    chk({tag, "_scoreboard_empty"}, qsize(id), 0);
  endtask

  // Line monitor: samples every negedge, decodes a frame, checks every bit is stable
  // for its whole period, and compares against the scoreboard head.
  task automatic monitor(input int id, input int dw, input int cpb, input int stops, input bit msb);
    int gap, nb;
    logic [15:0] obs, expv;
    logic [9:0] e;
    bit glitch, aborted;
    nb = 1 + dw + PAR + stops;
    forever begin
      gap = 0;
      @(negedge clk);
      while (tx_v[id] !== 1'b0 || !rst_n) begin gap++; @(negedge clk); end
      obs = '0;
      glitch = 1'b0;
      aborted = 1'b0;
      for (int b = 0; b < nb; b++) begin
        for (int s = 0; s < cpb; s++) begin
          if (!(b == 0 && s == 0)) @(negedge clk);
          if (!rst_n) aborted = 1'b1;
          if (s == 0) obs[b] = tx_v[id];
          else if (tx_v[id] !== obs[b]) glitch = 1'b1;
        end
      end
      if (!aborted) begin
        if (qsize(id) == 0) begin
          chk("unexpected_frame", qsize(id), 1);
        end else begin
          e = (id == 0) ? q0.pop_front() : q1.pop_front();
          expv = '0;
          for (int b = 0; b < dw; b++) expv[1+b] = msb ? e[dw-1-b] : e[b];
          if (PAR != 0) expv[1+dw] = e[9];
          for (int s = 0; s < stops; s++) expv[1+dw+PAR+s] = 1'b1;
          chk((id == 0) ? "frame_dut0" : "frame_dut1", obs, expv);
          chk((id == 0) ? "bit_stable_dut0" : "bit_stable_dut1", glitch, 0);
          if (id == 0) gaps0.push_back(gap); else gaps1.push_back(gap);
        end
      end
    end
  endtask

  initial monitor(0, 8, 16, 1, 1'b0);
  initial monitor(1, 7, 4, 2, 1'b1);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lb, lows;
    logic [7:0] burst [5];
    burst[0] = 8'h3C; burst[1] = 8'hFF; burst[2] = 8'h00; burst[3] = 8'h81; burst[4] = 8'h5A;
    rst_n = 1'b0; vld0 = 1'b0; vld1 = 1'b0; d0 = '0; d1 = '0; par_odd = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_ready", rdy0, 1);
    chk("rst_level", lvl0, 0);
    chk("rst_tx_dut1", tx1, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    single_frame(0, 8'hA5, 16 * (1 + 8 + PAR + 1) + 2, "a5");
    single_frame(1, 8'h41, 4 * (1 + 7 + PAR + 2) + 2, "msb41");

    // Two back-to-back words on the 2-stop-bit instance: no idle bits between frames.
    gaps1.delete();
    push(1, 8'h00, lb);
    push(1, 8'h41, lb);
    wait_idle(1, "b2b1");
    chk("b2b1_frames", gaps1.size(), 2);
    chk("b2b1_gap", (gaps1.size() > 1) ? gaps1[1] : -1, 0);

    // Burst: leader occupies the serialiser, then 5 words against a 4-deep FIFO.
    gaps0.delete();
    push(0, 8'h11, lb);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      push(0, burst[i], lb);
      chk("burst_level", lvl0, i + 1);
    end
    chk("burst_full_ready", rdy0, 0);
    push(0, burst[4], lb);
    chk("burst_level_at_pop", lb, 3);
    chk("burst_level_refill", lvl0, 4);
    wait_idle(0, "burst");
    chk("burst_frames", gaps0.size(), 6);
    for (int i = 1; i < 6; i++) chk("burst_gap", (gaps0.size() > i) ? gaps0[i] : -1, 0);

`ifdef UART_TX_PARITY_EN
    par_odd = 1'b0;
    single_frame(0, 8'h07, 16 * 11 + 2, "par_even");
    par_odd = 1'b1;
    single_frame(0, 8'h07, 16 * 11 + 2, "par_odd");
    par_odd = 1'b0;
`endif

    // Reset during the data bits of the second queued word.
    push(0, 8'hC3, lb);
    push(0, 8'h96, lb);
    push(0, 8'h5A, lb);
    repeat (16 * (1 + 8 + PAR + 1) + 40) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tx", tx0, 1);
    chk("midrst_busy", busy0, 0);
    chk("midrst_level", lvl0, 0);
    chk("midrst_sb_first_done", q0.size(), 2);
    q0.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    lows = 0;
    repeat (400) begin
      @(negedge clk);
      if (tx0 !== 1'b1) lows++;
    end
    chk("postrst_tx_idle", lows, 0);
    chk("postrst_level", lvl0, 0);
    chk("postrst_busy", busy0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
